// File: rtl/parity_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 9-bit parity
// generator, with a one-entry registered result stage and served counters.
module parity_rr_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [8:0]       req0_data,
    input  logic             req0_odd,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [8:0]       req1_data,
    input  logic             req1_odd,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [8:0]       res_data,
    output logic             res_parity,
    output logic             res_id,
    output logic [CNT_W-1:0] served0,
    output logic [CNT_W-1:0] served1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       last_gnt;
    logic       can_accept;
    logic       any_req;
    logic       gnt_id;
    logic       take0;
    logic       take1;
    logic       take;
    logic [8:0] sel_data;
    logic       sel_odd;
    logic       sel_parity;

    always_comb begin
        can_accept = !res_valid | res_ready;
        any_req    = req0_valid | req1_valid;
        // Contention goes to whoever did not win last; otherwise the sole requester.
        gnt_id     = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
        req0_ready = rst_n & can_accept & any_req & ~gnt_id;
        req1_ready = rst_n & can_accept & any_req & gnt_id;
        take0      = req0_valid & req0_ready;
        take1      = req1_valid & req1_ready;
        take       = take0 | take1;
        sel_data   = gnt_id ? req1_data : req0_data;
        sel_odd    = gnt_id ? req1_odd : req0_odd;
        sel_parity = (^sel_data) ^ sel_odd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_parity <= 1'b0;
            res_id     <= 1'b0;
            last_gnt   <= 1'b1;
        end else if (take) begin
            res_valid  <= 1'b1;
            res_data   <= sel_data;
            res_parity <= sel_parity;
            res_id     <= gnt_id;
            last_gnt   <= gnt_id;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served0 <= '0;
            served1 <= '0;
        end else begin
            if (take0 && served0 != CNT_MAX) served0 <= served0 + 1'b1;
            if (take1 && served1 != CNT_MAX) served1 <= served1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_rr_arbiter.sv
// Directed bench for parity_rr_arbiter: parity, round-robin, back-pressure,
// async reset and counter saturation (second instance with CNT_W=2).
module tb_parity_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_odd, req0_ready;
    logic       req1_valid, req1_odd, req1_ready;
    logic [8:0] req0_data, req1_data;
    logic       res_valid, res_ready, res_parity, res_id;
    logic [8:0] res_data;
    logic [7:0] served0, served1;

    logic       s_r0_ready, s_r1_ready, s_valid, s_parity, s_id;
    logic [8:0] s_data;
    logic [1:0] s_served0, s_served1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_rr_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_odd(req0_odd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_odd(req1_odd), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_parity(res_parity), .res_id(res_id),
        .served0(served0), .served1(served1)
    );

    parity_rr_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_odd(req0_odd), .req0_ready(s_r0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_odd(req1_odd), .req1_ready(s_r1_ready),
        .res_valid(s_valid), .res_ready(res_ready),
        .res_data(s_data), .res_parity(s_parity), .res_id(s_id),
        .served0(s_served0), .served1(s_served1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [8:0] d,
                           input logic p, input logic id);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_data"}, 32'(res_data), 32'(d));
        chk({tag, "_parity"}, 32'(res_parity), 32'(p));
        chk({tag, "_id"}, 32'(res_id), 32'(id));
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 9'h1FF;
        req0_odd   = 1'b0;
        req1_valid = 1'b0;
        req1_data  = 9'h000;
        req1_odd   = 1'b0;
        res_ready  = 1'b1;
        #12;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_parity", 32'(res_parity), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_served0", 32'(served0), 32'd0);
        chk("rst_served1", 32'(served1), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_ready0", 32'(req0_ready), 32'd1);

        // single requester, parity vectors
        tick();
        chk_res("p1ff_even", 9'h1FF, 1'b1, 1'b0);
        chk("p1ff_served0", 32'(served0), 32'd1);
        req0_odd = 1'b1;
        tick();
        chk_res("p1ff_odd", 9'h1FF, 1'b0, 1'b0);
        chk("p1ff_odd_served0", 32'(served0), 32'd2);
        req0_data = 9'h003; req0_odd = 1'b0;
        tick();
        chk_res("p003_even", 9'h003, 1'b0, 1'b0);
        req0_data = 9'h001; req0_odd = 1'b1;
        tick();
        chk_res("p001_odd", 9'h001, 1'b0, 1'b0);
        req0_data = 9'h000; req0_odd = 1'b1;
        tick();
        chk_res("p000_odd", 9'h000, 1'b1, 1'b0);
        chk("served0_5", 32'(served0), 32'd5);

        // drain with no transfer: valid drops, data held
        req0_valid = 1'b0;
        #1;
        chk("idle_ready0", 32'(req0_ready), 32'd0);
        chk("idle_ready1", 32'(req1_ready), 32'd0);
        tick();
        chk("drain_valid", 32'(res_valid), 32'd0);
        chk("drain_data_hold", 32'(res_data), 32'h000);
        chk("drain_parity_hold", 32'(res_parity), 32'd1);

        // req1 once so last grant is 1
        req1_valid = 1'b1; req1_data = 9'h0AA; req1_odd = 1'b0;
        tick();
        chk_res("r1_0aa", 9'h0AA, 1'b0, 1'b1);
        chk("r1_served1", 32'(served1), 32'd1);

        // fairness: both valid, res_ready high
        req0_valid = 1'b1; req0_data = 9'h155; req0_odd = 1'b0;
        req1_data = 9'h0F0; req1_odd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_one_ready", 32'(req0_ready + req1_ready), 32'd1);
            tick();
            if (i % 2 == 0) chk_res("rr_r0", 9'h155, 1'b1, 1'b0);
            else            chk_res("rr_r1", 9'h0F0, 1'b1, 1'b1);
        end
        chk("rr_served0", 32'(served0), 32'd8);
        chk("rr_served1", 32'(served1), 32'd4);

        // back-pressure: stage holds req1 word
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ready0", 32'(req0_ready), 32'd0);
            chk("stall_ready1", 32'(req1_ready), 32'd0);
            tick();
            chk_res("stall_hold", 9'h0F0, 1'b1, 1'b1);
        end
        chk("stall_served0", 32'(served0), 32'd8);
        res_ready = 1'b1;
        #1;
        chk("unstall_ready0", 32'(req0_ready), 32'd1);
        chk("unstall_ready1", 32'(req1_ready), 32'd0);
        tick();
        chk_res("refill", 9'h155, 1'b1, 1'b0);
        chk("refill_served0", 32'(served0), 32'd9);

        // async reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_data", 32'(res_data), 32'd0);
        chk("arst_parity", 32'(res_parity), 32'd0);
        chk("arst_served0", 32'(served0), 32'd0);
        chk("arst_served1", 32'(served1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(req0_ready), 32'd1);
        chk("post_rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        chk_res("post_rst", 9'h155, 1'b1, 1'b0);

        // saturation on the CNT_W=2 instance
        req0_valid = 1'b0;
        req1_data = 9'h001; req1_odd = 1'b0;
        tick();
        chk("sat_1", 32'(s_served1), 32'd1);
        chk("sat_parity", 32'(s_parity), 32'd1);
        tick();
        chk("sat_2", 32'(s_served1), 32'd2);
        tick();
        chk("sat_3", 32'(s_served1), 32'd3);
        tick();
        chk("sat_3b", 32'(s_served1), 32'd3);
        tick();
        chk("sat_3c", 32'(s_served1), 32'd3);
        chk("wide_served1", 32'(served1), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
